// File: rtl/intpol2_d4_out_fifo.sv
// intpol2_d4_out_fifo: output FIFO sitting directly behind the intpol2_D4
// interpolator datapath. It buffers one sample per FSM write strobe and
// returns the almost-full flag that throttles the FSM's streaming loop.
//
// Build option: define INTPOL2_OUT_FIFO_FWFT_EN for first-word fall-through
// reads (zero latency). The default build uses a registered read port with
// one cycle of latency.
//
// Occupancy is held in a single counter. full, empty and afull are decoded
// from that register only, so the FSM always sees glitch-free flags.
module intpol2_d4_out_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    // afull must rise while AFULL_MARGIN slots are still free, so that the
    // FSM's write loop can stop before anything is dropped.
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wa;
    logic                  ra;
    logic                  run;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign afull = (count >= AFULL_CNT);

    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when rd_en is high. There is no write-to-read bypass:
    // an empty FIFO ignores rd_en even if a write arrives alongside it.
    assign wa  = wr_en & (~full | rd_en);
    assign ra  = rd_en & ~empty;
    assign run = rstn & ~clear;

    // Storage array; writes are masked while reset or clear is active.
    always_ff @(posedge clk) begin
        if (run && wa) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wa, ra})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef INTPOL2_OUT_FIFO_FWFT_EN
    // Head of the queue is always on rd_data; rd_en only acknowledges it.
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    // Registered read port: popped word appears one cycle after rd_en and
    // is flagged by a single-cycle rd_valid. clear keeps the last word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ra;
            if (ra) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_intpol2_d4_out_fifo.sv
// Self-checking bench for intpol2_d4_out_fifo (default parameters).
// Works for both read modes; define INTPOL2_OUT_FIFO_FWFT_EN for both the
// design and this file to exercise first-word fall-through.
module tb_intpol2_d4_out_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        afull;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] q[$];
    int          m_count = 0;
    logic [31:0] m_rd_data = '0;

    // Per-step read observation vs. expectation
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        obs_valid;
    logic [31:0] obs_data;
    logic        data_chk;

    always #5 clk = ~clk;

    intpol2_d4_out_fifo #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (4),
        .AFULL_MARGIN(4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    // Drive one clock cycle of stimulus and advance the scoreboard model.
    // Leaves obs_* / exp_* describing the read side of this cycle.
    task automatic step(input bit wr, input logic [31:0] wd, input bit rd,
                        input bit clr, input bit rst);
        bit m_full;
        bit m_empty;
        bit wa;
        bit ra;
        @(negedge clk);
        rstn    = ~rst;
        clear   = clr;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        m_full  = (m_count == 16);
        m_empty = (m_count == 0);
        wa      = wr && (!m_full || rd);
        ra      = rd && !m_empty;
`ifdef INTPOL2_OUT_FIFO_FWFT_EN
        #1;
        exp_valid = !m_empty;
        exp_data  = m_empty ? 32'h0 : q[0];
        data_chk  = !m_empty;
        obs_valid = rd_valid;
        obs_data  = rd_data;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_count   = 0;
            m_rd_data = '0;
        end else if (clr) begin
            q.delete();
            m_count = 0;
        end else begin
            if (ra) begin
                m_rd_data = q.pop_front();
                m_count--;
            end
            if (wa) begin
                q.push_back(wd);
                m_count++;
            end
        end
`ifndef INTPOL2_OUT_FIFO_FWFT_EN
        exp_valid = ra && !rst && !clr;
        exp_data  = m_rd_data;
        data_chk  = 1'b1;
        obs_valid = rd_valid;
        obs_data  = rd_data;
`endif
    endtask

    task automatic test_reset();
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0) begin
            failures++; $display("FAIL reset_flags got empty=%b full=%b afull=%b exp 1 0 0", empty, full, afull); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_sticky got ovf=%b unf=%b exp 0 0", overflow, underflow); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
`ifndef INTPOL2_OUT_FIFO_FWFT_EN
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
`endif
    endtask

    task automatic test_basic();
        logic [31:0] exp_list [3];
        exp_list[0] = 32'h11; exp_list[1] = 32'h22; exp_list[2] = 32'h33;
        for (int i = 0; i < 3; i++) step(1, exp_list[i], 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 1, 0, 0);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== exp_list[i] || obs_data !== exp_data) begin
                failures++;
                $display("FAIL basic_read%0d got valid=%b data=%h exp valid=1 data=%h", i, obs_valid, obs_data, exp_list[i]);
            end
        end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL basic_drained got count=%0d empty=%b exp 0 1", count, empty); end
    endtask

    task automatic test_afull_full();
        for (int i = 1; i <= 16; i++) begin
            step(1, 32'h100 + i, 0, 0, 0);
            if (i == 11) begin
                checks++; if (afull !== 1'b0) begin failures++; $display("FAIL afull_11 got=%b exp=0", afull); end
            end
            if (i == 12) begin
                checks++; if (afull !== 1'b1) begin failures++; $display("FAIL afull_12 got=%b exp=1", afull); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_15 got=%b exp=0", full); end
            end
        end
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL full_16 got full=%b count=%0d exp 1 16", full, count); end
        // Simultaneous write and read on a full FIFO
        step(1, 32'h200, 1, 0, 0);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h101) begin
            failures++; $display("FAIL full_rw_pop got valid=%b data=%h exp 1 101", obs_valid, obs_data); end
        checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            failures++; $display("FAIL full_rw_state got count=%0d full=%b ovf=%b exp 16 1 0", count, full, overflow); end
        // Dropped write
        step(1, 32'h300, 0, 0, 0);
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL overflow got ovf=%b count=%0d exp 1 16", overflow, count); end
        for (int i = 0; i < 16; i++) begin
            step(0, 32'h0, 1, 0, 0);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== exp_data) begin
                failures++;
                $display("FAIL drain%0d got valid=%b data=%h exp valid=1 data=%h", i, obs_valid, obs_data, exp_data);
            end
        end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (count !== 5'd0 || underflow !== 1'b0 || overflow !== 1'b1) begin
            failures++; $display("FAIL drain_end got count=%0d unf=%b ovf=%b exp 0 0 1", count, underflow, overflow); end
    endtask

    task automatic test_underflow();
        step(0, 32'h0, 0, 1, 0);
        step(1, 32'hAB, 1, 0, 0);
        checks++;
        if (underflow !== 1'b1 || obs_valid !== 1'b0 || count !== 5'd1) begin
            failures++;
            $display("FAIL underflow got unf=%b valid=%b count=%0d exp 1 0 1", underflow, obs_valid, count);
        end
        step(0, 32'h0, 1, 0, 0);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'hAB) begin
            failures++; $display("FAIL underflow_read got valid=%b data=%h exp 1 ab", obs_valid, obs_data); end
        step(0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10; i++) step(1, 32'h400 + i, 0, 0, 0);
        step(1, 32'h999, 0, 1, 0);
        checks++; if (count !== 5'd0 || empty !== 1'b1 || afull !== 1'b0) begin
            failures++; $display("FAIL clear_flags got count=%0d empty=%b afull=%b exp 0 1 0", count, empty, afull); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL clear_sticky got ovf=%b unf=%b valid=%b exp 0 0 0", overflow, underflow, rd_valid); end
`ifndef INTPOL2_OUT_FIFO_FWFT_EN
        checks++; if (rd_data !== 32'hAB) begin failures++; $display("FAIL clear_rd_data got=%h exp=ab", rd_data); end
`endif
        for (int i = 0; i < 10; i++) step(1, 32'h500 + i, 0, 0, 0);
        step(1, 32'h777, 0, 0, 1);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL rst_burst got count=%0d empty=%b exp 0 1", count, empty); end
`ifndef INTPOL2_OUT_FIFO_FWFT_EN
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
`endif
        step(1, 32'h55, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h55) begin
            failures++; $display("FAIL rst_first_write got valid=%b data=%h exp 1 55", obs_valid, obs_data); end
        step(0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        int  next_wr = 0;
        int  next_rd = 0;
        int  cyc     = 0;
        bit  wr;
        bit  rd;
        step(0, 32'h0, 0, 1, 0);
        while (next_rd < 40 && cyc < 600) begin
            wr = (next_wr < 40) && (m_count < 15) && (m_count < 1 || $urandom_range(0, 2) != 0);
            rd = (m_count > 1 || (next_wr == 40 && m_count > 0)) && ($urandom_range(0, 1) == 1);
            step(wr, 32'(next_wr), rd, 0, 0);
            if (wr) next_wr++;
            if (rd) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== 32'(next_rd)) begin
                    failures++;
                    $display("FAIL wrap_data got valid=%b data=%0d exp valid=1 data=%0d", obs_valid, obs_data, next_rd);
                end
                next_rd++;
            end
            cyc++;
        end
        checks++; if (next_rd != 40) begin failures++; $display("FAIL wrap_budget got reads=%0d exp=40", next_rd); end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || count !== 5'd0) begin
            failures++; $display("FAIL wrap_end got ovf=%b unf=%b count=%0d exp 0 0 0", overflow, underflow, count); end
    endtask

    initial begin
        rstn    = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        test_reset();
        test_basic();
        test_afull_full();
        test_underflow();
        test_clear();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
